// File: rtl/mem_responder_if.sv
// ============================================================================
// mem_responder_if : CPU memory bus and program-loader handshake
// Rev 1.0
// ============================================================================
`default_nettype none

interface mem_responder_if #(
  parameter int WIDTH = 8
);
  logic             memread;
  logic             memwrite;
  logic [WIDTH-1:0] adr;
  logic [WIDTH-1:0] writedata;
  logic [WIDTH-1:0] memdata;
  logic             load_valid;
  logic [WIDTH-1:0] load_data;
  logic             load_done;
  logic             load_ready;

  modport master (
    output memread, memwrite, adr, writedata,
    output load_valid, load_data, load_done,
    input  memdata, load_ready
  );

  modport slave (
    input  memread, memwrite, adr, writedata,
    input  load_valid, load_data, load_done,
    output memdata, load_ready
  );
endinterface

`default_nettype wire

// File: rtl/mem_responder.sv
// ============================================================================
// mem_responder : byte memory with loader front-end and one memory-mapped I/O
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_responder #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] IO_ADDR = 8'hFF,
  parameter int               DEPTH   = 256
) (
  input  wire logic             clk,
  input  wire logic             rst,
  mem_responder_if.slave        bus,
  input  wire logic [WIDTH-1:0] io_in,
  output logic      [WIDTH-1:0] io_out,
  output logic                  cpu_rst
);

  localparam int               c_aw    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [WIDTH:0]   c_depth = (WIDTH + 1)'(DEPTH);
  localparam logic [WIDTH-1:0] c_last  = WIDTH'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_load_addr;
  logic [WIDTH-1:0] r_memdata;
  logic [WIDTH-1:0] r_io_out;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic             w_run;
  logic             w_cpu_io;
  logic             w_cpu_in_range;
  logic             w_mem_we;
  logic [c_aw-1:0]  w_mem_addr;
  logic [WIDTH-1:0] w_mem_wdata;
  logic [WIDTH-1:0] w_rd_data;

  assign w_run          = (r_state == ST_RUN);
  assign w_cpu_io       = (bus.adr == IO_ADDR);
  assign w_cpu_in_range = ({1'b0, bus.adr} < c_depth);

  // One shared write port: loader owns it in LOAD, CPU in RUN; the I/O address
  // never reaches storage from the CPU side.
  assign w_mem_we    = w_run ? (bus.memwrite && !w_cpu_io && w_cpu_in_range)
                             : bus.load_valid;
  assign w_mem_addr  = w_run ? bus.adr[c_aw-1:0] : r_load_addr[c_aw-1:0];
  assign w_mem_wdata = w_run ? bus.writedata : bus.load_data;
  assign w_rd_data   = w_cpu_in_range ? r_mem[bus.adr[c_aw-1:0]] : '0;

  // Storage has no reset so a program survives a CPU restart.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_LOAD;
      r_load_addr <= '0;
      r_memdata   <= '0;
      r_io_out    <= '0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          // The last storage byte ends loading instead of letting the pointer wrap.
          if (bus.load_valid) begin
            if (r_load_addr == c_last) begin
              r_state <= ST_RUN;
            end else begin
              r_load_addr <= r_load_addr + 1'b1;
            end
          end
          if (bus.load_done) begin
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (bus.memread) begin
            r_memdata <= w_cpu_io ? io_in : w_rd_data;
          end
          if (bus.memwrite && w_cpu_io) begin
            r_io_out <= bus.writedata;
          end
        end
        default: r_state <= ST_LOAD;
      endcase
    end
  end

  assign cpu_rst        = !w_run;
  assign bus.load_ready = !w_run;
  assign bus.memdata    = r_memdata;
  assign io_out         = r_io_out;

endmodule

`default_nettype wire

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter WIDTH, default 8, data and address width in bits.
REQ-002 Parameter IO_ADDR, default 8'hFF, memory-mapped I/O address.
REQ-003 Parameter DEPTH, default 256, storage bytes; addresses 0..DEPTH-1.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 memread  input  1  CPU read request.
REQ-007 memwrite  input  1  CPU write request.
REQ-008 adr  input  WIDTH  CPU byte address.
REQ-009 writedata  input  WIDTH  CPU write data.
REQ-010 memdata  output  WIDTH  registered read data returned to CPU.
REQ-011 load_valid  input  1  loader byte valid.
REQ-012 load_data  input  WIDTH  loader byte.
REQ-013 load_done  input  1  loader end-of-program pulse.
REQ-014 load_ready  output  1  responder accepts loader bytes.
REQ-015 cpu_rst  output  1  active-high reset to the CPU; held while loading.
REQ-016 io_in  input  WIDTH  external input, read at IO_ADDR.
REQ-017 io_out  output  WIDTH  registered external output, written at IO_ADDR.

Function
REQ-018 The block SHALL implement a two-state FSM: LOAD and RUN.
REQ-019 In LOAD: load_ready=1, cpu_rst=1; memread/memwrite ignored.
REQ-020 In LOAD, load_valid=1 SHALL write load_data to mem[load_addr] and increment the WIDTH-bit load_addr on that edge.
REQ-021 LOAD->RUN SHALL occur on the edge where load_done=1, or where a byte is written at load_addr=DEPTH-1.
REQ-022 load_valid and load_done on the same edge: byte written first, then RUN entered.
REQ-023 load_addr SHALL NOT wrap; transition to RUN precedes any wrap.
REQ-024 In RUN: load_ready=0, cpu_rst=0, loader inputs ignored; RUN held until reset.
REQ-025 cpu_rst and load_ready SHALL be decoded from the registered state only: cpu_rst falls in the first RUN cycle.
REQ-026 RUN, memwrite=1: adr==IO_ADDR -> io_out<=writedata, storage unchanged; else mem[adr]<=writedata.
REQ-027 RUN, memread=1: memdata SHALL load io_in if adr==IO_ADDR, else mem[adr]; one-cycle latency, valid the cycle after the request edge.
REQ-028 memdata SHALL hold its value whenever memread=0.
REQ-029 memread and memwrite together: write performed and memdata loads the pre-write value (read-before-write).
REQ-030 io_out SHALL change only on an IO_ADDR write in RUN.
REQ-031 When IO_ADDR<DEPTH, mem[IO_ADDR] SHALL be reachable only through the loader, never through the CPU port.

Reset
REQ-032 rst=0 SHALL immediately force: state=LOAD, load_addr=0, memdata=0, io_out=0; hence cpu_rst=1, load_ready=1.
REQ-033 Storage contents SHALL NOT be cleared by reset.
REQ-034 Reset asserted mid-RUN SHALL re-enter LOAD with load_addr=0 and re-hold the CPU in reset.
REQ-035 Reset release SHALL take effect on the first rising clk after rst=1.

Verification
REQ-036 Load 0x11,0x22,0x33 then load_done pulse -> mem[0..2]=11,22,33; cpu_rst 1->0 on the edge after load_done; load_ready=0.
REQ-037 RUN, memread adr=0x01 -> memdata=0x22 next cycle; memread dropped -> memdata stays 0x22.
REQ-038 RUN, memwrite adr=0xFF data=0xA5 -> io_out=0xA5, mem untouched; io_in=0x3C, memread adr=0xFF -> memdata=0x3C.
REQ-039 RUN, memread+memwrite adr=0x02 data=0x77 -> memdata=0x33 next cycle; following read -> 0x77.
REQ-040 Load 256 bytes without load_done -> RUN entered on the 256th byte; extra load_valid ignored.
REQ-041 Assert rst mid-RUN with io_out=0xA5 -> io_out=0, memdata=0, cpu_rst=1 immediately; mem[0..2] retained.
